if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 14 +
 rtl/if_fetch_watchdog.sv | 33 +++
 rtl/if_fetch.sv | 133 +++++++++++++
 tb/tb_if_fetch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings,
// the default NOP word and the watchdog counter width.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam int          WDOG_W            = 32;

endpackage

// File: rtl/if_fetch_watchdog.sv
// Cycle counter that flags a memory request outstanding for too long.
// The count saturates once expired so it can never wrap back to a quiet value.
module fetch_watchdog
    import if_fetch_pkg::*;
#(
    parameter int W = WDOG_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W:0]   count_inc;

    assign count_inc = {1'b0, count_q} + {{W{1'b0}}, 1'b1};

    // Expires during the limit-th counted cycle, so the error lands right after it.
    assign expired = enable && (count_inc >= {1'b0, limit});

    // Count enabled cycles, restarting whenever the owner clears it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_inc[W-1:0];
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding read to instruction memory,
// a single-entry output buffer towards decode, flush handling and
// sticky misalignment / timeout errors.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR      = NOP_INSTR_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        pc_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        decode_ready,
    output logic        addr_err,
    output logic        bus_err
);

    fetch_state_e state_q;
    logic         mem_req_q;
    logic [31:0]  mem_addr_q;
    logic [31:0]  instr_q;
    logic [31:0]  instr_pc_q;
    logic         instr_valid_q;
    logic         addr_err_q;
    logic         bus_err_q;

    logic         free;
    logic         can_issue;
    logic         wd_expired;

    // Buffer slot is free when empty or being consumed this cycle.
    assign free      = !instr_valid_q || decode_ready;
    assign can_issue = free && !flush && !addr_err_q && !bus_err_q;

    // PC moves only on an accepted (non-flushed) response; held during reset.
    assign pc_stall = rst || !((state_q == ST_WAIT) && mem_ack && !flush);

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign addr_err    = addr_err_q;
    assign bus_err     = bus_err_q;

    fetch_watchdog #(
        .W (WDOG_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == ST_IDLE),
        .enable  (state_q != ST_IDLE),
        .limit   (WDOG_W'(TIMEOUT_CYCLES)),
        .expired (wd_expired)
    );

    // Fetch FSM with all outputs registered; ack takes priority over timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'h0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            if (instr_valid_q && decode_ready) begin
                instr_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (flush) begin
                        instr_valid_q <= 1'b0;
                    end else if (can_issue) begin
                        if (pc[1:0] == 2'b00) begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= pc;
                            state_q    <= ST_WAIT;
                        end else begin
                            addr_err_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        instr_valid_q <= 1'b0;
                    end
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                        if (!flush) begin
                            instr_q       <= mem_rdata;
                            instr_pc_q    <= mem_addr_q;
                            instr_valid_q <= 1'b1;
                        end
                    end else if (wd_expired) begin
                        bus_err_q <= 1'b1;
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (flush) begin
                        state_q <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (wd_expired) begin
                        bus_err_q <= 1'b1;
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with hand-computed expectations.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        flush;
    logic        pc_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        decode_ready;
    logic        addr_err;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_fetch #(
        .NOP_INSTR      (NOP),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .flush        (flush),
        .pc_stall     (pc_stall),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .decode_ready (decode_ready),
        .addr_err     (addr_err),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(mem_req), 32'd0);
        chk({tag, "_addr"},  mem_addr, 32'h0);
        chk({tag, "_instr"}, instr, NOP);
        chk({tag, "_ipc"},   instr_pc, 32'h0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_aerr"},  32'(addr_err), 32'd0);
        chk({tag, "_berr"},  32'(bus_err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout_guard simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; pc = 32'h0; flush = 1'b0; mem_ack = 1'b0;
        mem_rdata = 32'h0; decode_ready = 1'b0;
        tick();
        tick();
        chk("rst_stall", 32'(pc_stall), 32'd1);
        chk_reset_outputs("rst");

        // Fetch at 0x40 with ack in the third request cycle
        rst = 1'b0; pc = 32'h40; decode_ready = 1'b1;
        #1 chk("a_stall_idle", 32'(pc_stall), 32'd1);
        tick();
        chk("a_req0", 32'(mem_req), 32'd1);
        chk("a_addr0", mem_addr, 32'h40);
        chk("a_stall0", 32'(pc_stall), 32'd1);
        tick();
        chk("a_req1", 32'(mem_req), 32'd1);
        chk("a_addr1", mem_addr, 32'h40);
        chk("a_stall1", 32'(pc_stall), 32'd1);
        tick();
        chk("a_req2", 32'(mem_req), 32'd1);
        chk("a_addr2", mem_addr, 32'h40);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678; decode_ready = 1'b0;
        #1 chk("a_stall_ack", 32'(pc_stall), 32'd0);
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk("a_req_done", 32'(mem_req), 32'd0);
        chk("a_valid", 32'(instr_valid), 32'd1);
        chk("a_instr", instr, 32'h1234_5678);
        chk("a_ipc", instr_pc, 32'h40);
        #1 chk("a_stall_after", 32'(pc_stall), 32'd1);

        // Decode back-pressure: everything holds
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("h_instr", instr, 32'h1234_5678);
            chk("h_valid", 32'(instr_valid), 32'd1);
            chk("h_req", 32'(mem_req), 32'd0);
            chk("h_stall", 32'(pc_stall), 32'd1);
        end

        // Zero-wait stream 0x0, 0x4, 0x8
        decode_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 32'(4 * i);
            tick();
            chk("s_req", 32'(mem_req), 32'd1);
            chk("s_addr", mem_addr, 32'(4 * i));
            chk("s_valid_gap", 32'(instr_valid), 32'd0);
            mem_ack = 1'b1; mem_rdata = 32'hA000_0000 + 32'(i);
            #1 chk("s_stall", 32'(pc_stall), 32'd0);
            tick();
            mem_ack = 1'b0;
            chk("s_valid", 32'(instr_valid), 32'd1);
            chk("s_ipc", instr_pc, 32'(4 * i));
            chk("s_instr", instr, 32'hA000_0000 + 32'(i));
            chk("s_req_low", 32'(mem_req), 32'd0);
        end

        // Flush while idle with a buffered instruction
        pc = 32'hC; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fi_valid", 32'(instr_valid), 32'd0);
        chk("fi_req", 32'(mem_req), 32'd0);

        // Flush during an outstanding request; response must be dropped
        pc = 32'h100;
        tick();
        chk("fw_req0", 32'(mem_req), 32'd1);
        chk("fw_addr0", mem_addr, 32'h100);
        flush = 1'b1; pc = 32'h200;
        tick();
        flush = 1'b0;
        chk("fw_req1", 32'(mem_req), 32'd1);
        chk("fw_addr1", mem_addr, 32'h100);
        chk("fw_valid1", 32'(instr_valid), 32'd0);
        tick();
        chk("fw_req2", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1 chk("fw_stall_discard", 32'(pc_stall), 32'd1);
        tick();
        mem_ack = 1'b0;
        chk("fw_valid_drop", 32'(instr_valid), 32'd0);
        chk("fw_req_low", 32'(mem_req), 32'd0);
        tick();
        chk("fw_new_req", 32'(mem_req), 32'd1);
        chk("fw_new_addr", mem_addr, 32'h200);
        chk("fw_valid_still0", 32'(instr_valid), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_C0DE; decode_ready = 1'b0;
        tick();
        mem_ack = 1'b0;
        chk("fw_new_valid", 32'(instr_valid), 32'd1);
        chk("fw_new_ipc", instr_pc, 32'h200);
        chk("fw_new_instr", instr, 32'h0000_C0DE);

        // Misaligned PC: sticky addr_err, no request
        pc = 32'h42; decode_ready = 1'b1;
        tick();
        chk("ae_set", 32'(addr_err), 32'd1);
        chk("ae_req", 32'(mem_req), 32'd0);
        chk("ae_valid", 32'(instr_valid), 32'd0);
        pc = 32'h44;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ae_sticky", 32'(addr_err), 32'd1);
            chk("ae_noreq", 32'(mem_req), 32'd0);
        end
        rst = 1'b1;
        tick();
        chk("ae_rst", 32'(addr_err), 32'd0);

        // Timeout with TIMEOUT_CYCLES=4
        rst = 1'b0; pc = 32'h80;
        tick();
        chk("to_req0", 32'(mem_req), 32'd1);
        chk("to_addr0", mem_addr, 32'h80);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("to_req_wait", 32'(mem_req), 32'd1);
            chk("to_berr_wait", 32'(bus_err), 32'd0);
        end
        tick();
        chk("to_berr", 32'(bus_err), 32'd1);
        chk("to_req_drop", 32'(mem_req), 32'd0);
        tick();
        chk("to_berr_sticky", 32'(bus_err), 32'd1);
        chk("to_noreq", 32'(mem_req), 32'd0);
        rst = 1'b1;
        tick();
        chk_reset_outputs("to_rst");

        // Reset mid-request, then a stale ack while idle
        rst = 1'b0; pc = 32'h90;
        tick();
        chk("mr_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        tick();
        chk("mr_req_drop", 32'(mem_req), 32'd0);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_ack = 1'b0;
        chk("mr_stale_valid", 32'(instr_valid), 32'd0);
        chk("mr_new_req", 32'(mem_req), 32'd1);
        chk("mr_new_addr", mem_addr, 32'h90);
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ack = 1'b0;
        chk("mr_valid", 32'(instr_valid), 32'd1);
        chk("mr_instr", instr, 32'h5555_AAAA);
        chk("mr_ipc", instr_pc, 32'h90);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
